// File: rtl/fifo_arb_pkg.sv
// Shared types and parameter defaults for the shared-FIFO write arbiter.
package fifo_arb_pkg;

    localparam int unsigned DefDataWidth = 8;
    localparam int unsigned DefNumReq    = 4;
    localparam int unsigned DefMaxBurst  = 4;

    typedef enum logic {
        StIdle,
        StGrant
    } arb_state_e;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO-side bundle of the write arbiter; master drives requests, slave arbitrates.
interface fifo_wr_arbiter_if #(
    parameter int unsigned DATA_WIDTH = fifo_arb_pkg::DefDataWidth,
    parameter int unsigned NUM_REQ    = fifo_arb_pkg::DefNumReq
) ();

    localparam int unsigned IdxW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]            req;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic                          fifo_full;
    logic [NUM_REQ-1:0]            gnt;
    logic [IdxW-1:0]               grant_id;
    logic                          busy;
    logic                          fifo_wr_en;
    logic [DATA_WIDTH-1:0]         fifo_wdata;

    modport master (
        output req, req_data, fifo_full,
        input  gnt, grant_id, busy, fifo_wr_en, fifo_wdata
    );

    modport slave (
        input  req, req_data, fifo_full,
        output gnt, grant_id, busy, fifo_wr_en, fifo_wdata
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin search: first requester above last_owner, wrapping.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IdxW    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IdxW-1:0]    last_owner,
    output logic               valid,
    output logic [IdxW-1:0]    idx
);

    logic [IdxW-1:0] cand;

    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        // Offset 1..NUM_REQ so last_owner itself is considered last.
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            cand = IdxW'((32'(last_owner) + i) % NUM_REQ);
            if (!valid && req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: one requester owns the shared FIFO for up to MAX_BURST writes.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DefDataWidth,
    parameter int unsigned NUM_REQ    = DefNumReq,
    parameter int unsigned MAX_BURST  = DefMaxBurst
) (
    input logic              clk,
    input logic              rst,
    fifo_wr_arbiter_if.slave bus
);

    localparam int unsigned IdxW = $clog2(NUM_REQ);
    localparam int unsigned CntW = $clog2(MAX_BURST + 1);

    arb_state_e         state_q, state_d;
    logic [IdxW-1:0]    owner_q, owner_d;
    logic [IdxW-1:0]    last_q, last_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               busy_q, busy_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic               pick_valid;
    logic [IdxW-1:0]    pick_idx;
    logic               owner_req;
    logic               wr_en;
    logic               rel;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IdxW    (IdxW)
    ) u_rr_pick (
        .req        (bus.req),
        .last_owner (last_q),
        .valid      (pick_valid),
        .idx        (pick_idx)
    );

    assign owner_req = bus.req[owner_q];
    // Gate with rst so an aborted tenure never writes in the reset cycle.
    assign wr_en     = (state_q == StGrant) && owner_req && !bus.fifo_full && !rst;

    assign bus.fifo_wr_en = wr_en;
    assign bus.gnt        = gnt_q;
    assign bus.grant_id   = owner_q;
    assign bus.busy       = busy_q;

    always_comb begin
        bus.fifo_wdata = '0;
        if (wr_en) begin
            bus.fifo_wdata = bus.req_data[int'(owner_q) * DATA_WIDTH +: DATA_WIDTH];
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        rel     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pick_valid) begin
                    state_d = StGrant;
                    owner_d = pick_idx;
                    gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            StGrant: begin
                if (!owner_req) begin
                    rel = 1'b1;
                end else if (wr_en) begin
                    if (cnt_q == CntW'(MAX_BURST - 1)) begin
                        rel = 1'b1;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                // fifo_full with the owner still requesting: hold everything.
            end
            default: state_d = StIdle;
        endcase

        if (rel) begin
            state_d = StIdle;
            last_d  = owner_q;
            owner_d = '0;
            gnt_d   = '0;
            busy_d  = 1'b0;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            owner_q <= '0;
            last_q  <= IdxW'(NUM_REQ - 1);
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
